// File: rtl/tx_control_arb_module.sv
// Purpose: single-wire frame transmitter (start, 32 data LSB-first, even parity, stop) with collision abort, random backoff and bounded retry.
// Latency: request accepted in IDLE, first bus drive one cycle after bus_idle is seen; every bit change follows its BPS_CLK tick by one cycle.
// Backpressure: Tx_Busy high outside IDLE; requests arriving while busy are dropped, a waiting frame holds off while bus_idle=0 or Tx_Cancel=1.
module tx_control_arb_module #(
  parameter int unsigned MAX_RETRY    = 4,
  parameter int unsigned BACKOFF_BITS = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Tx_En_Sig,
  input  logic [31:0] Tx_Data,
  input  logic        BPS_CLK,
  input  logic        bus_idle,
  input  logic        Tx_Cancel,
  output logic        Count_Sig,
  output logic        Tx_Pin_Out,
  output logic        Tx_Pin_to_Rx,
  output logic        Tx_Transmit_now,
  output logic        Tx_Done_Sig,
  output logic        Tx_Fail_Sig,
  output logic        Tx_Busy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW = BACKOFF_BITS + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_BACKOFF,
    S_FAIL
  } state_t;

  state_t          state_q;
  logic [31:0]     data_q;
  logic            parity_q;
  logic [4:0]      bit_idx_q;
  logic [RW-1:0]   retry_q;
  logic [BW-1:0]   bo_cnt_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_d;
  logic            pin_q;
  logic            count_q;
  logic            txnow_q;
  logic            done_q;
  logic            fail_q;

  logic            collide;
  logic            retry_full;
  logic [BW-1:0]   bo_load;
  logic [4:0]      next_idx;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Collision only matters while start, data or parity bits are on the wire
  assign collide    = Tx_Cancel && ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_PARITY));
  assign retry_full = (retry_q == RW'(MAX_RETRY));
  assign bo_load    = {1'b0, lfsr_q[BACKOFF_BITS-1:0]} + BW'(1);
  assign next_idx   = bit_idx_q + 5'd1;

  // Backoff randomiser free-runs every cycle so retry timing decorrelates between transmitters
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Frame sequencer with registered bus-facing outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      retry_q   <= '0;
      bo_cnt_q  <= '0;
      pin_q     <= 1'b1;
      count_q   <= 1'b0;
      txnow_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      if (collide) begin
        // Release the bus immediately; cancel has priority over a coincident tick
        pin_q     <= 1'b1;
        txnow_q   <= 1'b0;
        bit_idx_q <= '0;
        if (retry_full) begin
          state_q <= S_FAIL;
          fail_q  <= 1'b1;
          count_q <= 1'b0;
        end else begin
          retry_q  <= retry_q + RW'(1);
          bo_cnt_q <= bo_load;
          count_q  <= 1'b1;
          state_q  <= S_BACKOFF;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            pin_q   <= 1'b1;
            count_q <= 1'b0;
            txnow_q <= 1'b0;
            if (Tx_En_Sig) begin
              data_q   <= Tx_Data;
              parity_q <= ^Tx_Data;
              retry_q  <= '0;
              state_q  <= S_WAIT_BUS;
            end
          end
          S_WAIT_BUS: begin
            // Baud counter held off here so the start bit gets a full period
            count_q <= 1'b0;
            if (bus_idle && !Tx_Cancel) begin
              pin_q     <= 1'b0;
              count_q   <= 1'b1;
              txnow_q   <= 1'b1;
              bit_idx_q <= '0;
              state_q   <= S_START;
            end
          end
          S_START: begin
            if (BPS_CLK) begin
              pin_q     <= data_q[0];
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end
          end
          S_DATA: begin
            if (BPS_CLK) begin
              if (bit_idx_q == 5'd31) begin
                pin_q   <= parity_q;
                state_q <= S_PARITY;
              end else begin
                pin_q     <= data_q[next_idx];
                bit_idx_q <= next_idx;
              end
            end
          end
          S_PARITY: begin
            if (BPS_CLK) begin
              pin_q   <= 1'b1;
              txnow_q <= 1'b0;
              state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (BPS_CLK) begin
              done_q  <= 1'b1;
              count_q <= 1'b0;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          S_BACKOFF: begin
            if (BPS_CLK) begin
              bo_cnt_q <= bo_cnt_q - BW'(1);
              if (bo_cnt_q == BW'(1)) begin
                count_q <= 1'b0;
                state_q <= S_WAIT_BUS;
              end
            end
          end
          S_FAIL: begin
            state_q <= S_IDLE;
          end
          default: begin
            pin_q   <= 1'b1;
            count_q <= 1'b0;
            txnow_q <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Count_Sig       = count_q;
  assign Tx_Pin_Out      = pin_q;
  assign Tx_Pin_to_Rx    = pin_q;
  assign Tx_Transmit_now = txnow_q;
  assign Tx_Done_Sig     = done_q;
  assign Tx_Fail_Sig     = fail_q;
  assign Tx_Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_control_arb_module.sv
// Purpose: randomized + directed bench for tx_control_arb_module with a queue scoreboard and protocol-level frame model.
// Latency: outputs sampled on the falling edge; stimulus and baud ticks driven shortly after the rising edge.
// Backpressure: requests are issued only once the previous frame has ended (done, fail or reset).
module tb_tx_control_arb_module;

  localparam int MAX_RETRY    = 4;
  localparam int BACKOFF_BITS = 4;
  localparam int BO_MAX       = 1 << BACKOFF_BITS;
  localparam int BUDGET       = 12000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Tx_En_Sig = 1'b0;
  logic [31:0] Tx_Data = 32'h0;
  logic        BPS_CLK = 1'b0;
  logic        bus_idle = 1'b1;
  logic        Tx_Cancel = 1'b0;
  logic        Count_Sig, Tx_Pin_Out, Tx_Pin_to_Rx, Tx_Transmit_now;
  logic        Tx_Done_Sig, Tx_Fail_Sig, Tx_Busy;

  tx_control_arb_module #(
    .MAX_RETRY   (MAX_RETRY),
    .BACKOFF_BITS(BACKOFF_BITS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Tx_En_Sig      (Tx_En_Sig),
    .Tx_Data        (Tx_Data),
    .BPS_CLK        (BPS_CLK),
    .bus_idle       (bus_idle),
    .Tx_Cancel      (Tx_Cancel),
    .Count_Sig      (Count_Sig),
    .Tx_Pin_Out     (Tx_Pin_Out),
    .Tx_Pin_to_Rx   (Tx_Pin_to_Rx),
    .Tx_Transmit_now(Tx_Transmit_now),
    .Tx_Done_Sig    (Tx_Done_Sig),
    .Tx_Fail_Sig    (Tx_Fail_Sig),
    .Tx_Busy        (Tx_Busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [31:0] w;
    bit          fail;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // External baud counter: free-runs while Count_Sig=1, one tick every 16 cycles
  int baud_cnt = 0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (Count_Sig !== 1'b1) baud_cnt = 0;
      else baud_cnt = (baud_cnt + 1) % 16;
      BPS_CLK = (Count_Sig === 1'b1) && (baud_cnt == 15);
    end
  end

  // Monitor: frame-level model of what should be on the wire
  typedef enum int {P_IDLE, P_WAIT, P_TX, P_STOP, P_BO, P_DONE, P_FAIL} ph_t;
  ph_t  ph = P_IDLE;
  int   n = 0;
  int   aborts = 0;
  int   bo_ticks = 0;
  bit   prev_tick = 1'b0;
  exp_t cur;
  logic e_busy, e_pin, e_cnt, e_tx, e_done, e_fail;

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_on) begin
        if (sb.size() > 0) cur = sb[0];
        else begin
          cur.w    = 32'h0;
          cur.fail = 1'b0;
        end
        chk("pin_to_rx_copy", Tx_Pin_to_Rx, Tx_Pin_Out);
        if (ph == P_BO && Count_Sig === 1'b0) begin
          chk("backoff_min_ticks", 32'(bo_ticks >= 1), 1);
          chk("backoff_max_ticks", 32'(bo_ticks <= BO_MAX), 1);
          chk("backoff_ends_on_tick", prev_tick, 1);
          ph = P_WAIT;
        end
        e_busy = 1'b1; e_pin = 1'b1; e_cnt = 1'b0; e_tx = 1'b0; e_done = 1'b0; e_fail = 1'b0;
        case (ph)
          P_IDLE: e_busy = 1'b0;
          P_TX: begin
            e_cnt = 1'b1;
            e_tx  = 1'b1;
            if (n == 0) e_pin = 1'b0;
            else if (n <= 32) e_pin = cur.w[n-1];
            else e_pin = ^cur.w;
          end
          P_STOP, P_BO: e_cnt = 1'b1;
          P_DONE: e_done = 1'b1;
          P_FAIL: e_fail = 1'b1;
          default: ;
        endcase
        chk($sformatf("busy ph=%0d", ph), Tx_Busy, e_busy);
        chk($sformatf("pin ph=%0d bit=%0d", ph, n), Tx_Pin_Out, e_pin);
        chk($sformatf("count_sig ph=%0d", ph), Count_Sig, e_cnt);
        chk($sformatf("transmit_now ph=%0d", ph), Tx_Transmit_now, e_tx);
        chk($sformatf("done ph=%0d", ph), Tx_Done_Sig, e_done);
        chk($sformatf("fail ph=%0d", ph), Tx_Fail_Sig, e_fail);
        if (Tx_Done_Sig === 1'b1 || Tx_Fail_Sig === 1'b1) begin
          chk("outcome_has_item", 32'(sb.size() > 0), 1);
          chk("outcome_vs_plan", Tx_Fail_Sig, cur.fail);
        end
        prev_tick = BPS_CLK;
        if (RST) begin
          if (ph != P_IDLE && sb.size() > 0) void'(sb.pop_front());
          ph = P_IDLE;
        end else begin
          case (ph)
            P_IDLE: if (Tx_En_Sig) begin
              chk("request_has_item", 32'(sb.size() > 0), 1);
              aborts = 0;
              ph = P_WAIT;
            end
            P_WAIT: if (bus_idle && !Tx_Cancel) begin
              n  = 0;
              ph = P_TX;
            end
            P_TX: begin
              if (Tx_Cancel) begin
                aborts++;
                bo_ticks = 0;
                ph = (aborts > MAX_RETRY) ? P_FAIL : P_BO;
              end else if (BPS_CLK) begin
                n++;
                if (n == 34) ph = P_STOP;
              end
            end
            P_STOP: if (BPS_CLK) ph = P_DONE;
            P_BO: if (BPS_CLK) bo_ticks++;
            P_DONE, P_FAIL: begin
              if (sb.size() > 0) void'(sb.pop_front());
              ph = P_IDLE;
            end
            default: ph = P_IDLE;
          endcase
        end
      end
    end
  end

  // One request: k planned collisions, optional first-collision cycle, busy-time
  // injection, mid-frame reset, cancel/bus noise, and a bus_idle hold after the request
  task automatic run_frame(input logic [31:0] w, input int k, input int first_tgt,
                           input int inject_at, input int reset_at, input bit noise,
                           input int idle_hold);
    exp_t e;
    int   cyc;
    int   ab;
    int   tgt;
    bit   finished;
    e.w    = w;
    e.fail = (k > MAX_RETRY);
    sb.push_back(e);
    @(posedge CLK);
    #2;
    Tx_En_Sig = 1'b1;
    Tx_Data   = w;
    if (idle_hold > 0) bus_idle = 1'b0;
    cyc = 0;
    ab  = 0;
    tgt = (first_tgt >= 0) ? first_tgt : int'($urandom_range(0, 400));
    finished = 1'b0;
    for (int t = 0; t < BUDGET && !finished; t++) begin
      @(posedge CLK);
      #2;
      Tx_En_Sig = 1'b0;
      Tx_Data   = $urandom;
      Tx_Cancel = 1'b0;
      if (t == idle_hold) bus_idle = 1'b1;
      if (t == inject_at) begin
        Tx_En_Sig = 1'b1;
        Tx_Data   = 32'hFFFFFFFF;
      end
      if (noise) bus_idle = ($urandom_range(0, 3) != 0);
      if (Tx_Done_Sig || Tx_Fail_Sig) begin
        finished = 1'b1;
      end else if (Tx_Transmit_now) begin
        if (reset_at >= 0 && cyc == reset_at) begin
          RST = 1'b1;
          @(posedge CLK);
          #2;
          RST = 1'b0;
          finished = 1'b1;
        end else if (ab < k && cyc == tgt) begin
          Tx_Cancel = 1'b1;
          ab++;
          tgt = $urandom_range(0, 400);
        end
        cyc++;
      end else begin
        cyc = 0;
        if (noise && Tx_Busy && $urandom_range(0, 7) == 0) Tx_Cancel = 1'b1;
      end
    end
    chk("frame_finished_in_budget", 32'(finished), 1);
    Tx_Cancel = 1'b0;
    Tx_En_Sig = 1'b0;
    bus_idle  = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    RST    = 1'b0;
    mon_on = 1'b1;
    repeat (5) @(posedge CLK);
    // clean frame, parity 0
    run_frame(32'hA5A50F0F, 0, -1, -1, -1, 1'b0, -1);
    // collision during data bit 5, one retry
    run_frame(32'h13579BDF, 1, 104, -1, -1, 1'b0, -1);
    // collision on every attempt -> fail
    run_frame(32'hDEADBEEF, MAX_RETRY + 1, -1, -1, -1, 1'b0, -1);
    // bus busy for 200 cycles after the request
    run_frame(32'h0F1E2D3C, 0, -1, -1, -1, 1'b0, 200);
    // reset mid-data, then a clean frame
    run_frame(32'h55AA33CC, 0, -1, -1, 300, 1'b0, -1);
    run_frame(32'h2468ACE0, 0, -1, -1, -1, 1'b0, -1);
    // request while busy is ignored; parity 1
    run_frame(32'h00000001, 0, -1, 40, -1, 1'b0, -1);
    // randomized frames
    for (int i = 0; i < 10; i++) begin
      run_frame($urandom, $urandom_range(0, MAX_RETRY + 1), -1,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 300)) : -1,
                -1, 1'b1, -1);
    end
    repeat (20) @(posedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
